instr_mem_init_responder: RTL and testbench
===========================================

Name: instr_mem_init_responder

Overview:
- Responder end of the instruction-initialize interface: accepts address/data pairs presented while `initialize` is high and writes them into a word-addressed instruction RAM.
- Serves the CPU fetch port with 1-cycle registered reads.
- Tracks load status: highest word written, error flags, done pulse.
- Provides a valid/ready readback stream so a bench or debug host can dump the loaded program.

Parameters:
- DEPTH, 64, number of 32-bit instruction words; must be a power of two ≥ 2.
- AW, 6, word-index width = log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- initialize  in  1  high = load mode; fetch and readback are blocked.
- instruction_initialize_address  in  32  byte address of the word to write.
- instruction_initialize_data  in  32  instruction word to write.
- fetch_addr  in  32  byte address from the CPU PC.
- fetch_instr  out  32  instruction at the fetch_addr presented in the previous cycle.
- cpu_run  out  1  high when the program is loaded and error-free; gates the CPU.
- load_done  out  1  1-cycle pulse on leaving load mode.
- max_index  out  AW  highest word index written since the last load start.
- err_misaligned  out  1  sticky: a load address had bits [1:0] ≠ 0.
- err_range  out  1  sticky: a load address was ≥ DEPTH*4.
- dump_start  in  1  1-cycle request to stream words 0..max_index.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the word.
- dump_data  out  32  dump word.
- dump_index  out  AW  index of dump_data.

Behaviour:
- **Reset (rst=0, async):**
  - All outputs are 0; FSM goes to IDLE.
  - Error flags, max_index and the written flag are cleared.
  - RAM contents are not cleared.
  - Reset asserted mid-load or mid-dump aborts immediately; no partial handshake completes.
- **FSM states:** IDLE, LOAD, RUN, DUMP.
- **IDLE → LOAD** when initialize=1.
  - On entering LOAD, clear the error flags, max_index and the written flag.
- **In LOAD, every cycle with initialize=1:**
  - If the address is aligned and in range, write `mem[addr[AW+1:2]] <= data`. Repeated identical writes are harmless.
  - Update max_index to the larger of max_index and the write index.
  - Set the written flag.
  - A misaligned address sets err_misaligned and does not write.
  - An out-of-range address sets err_range and does not write.
  - A misaligned and out-of-range address sets both flags.
- **LOAD → RUN** on the first cycle with initialize=0.
  - load_done pulses on that cycle.
  - cpu_run = 1 from the next cycle only if the written flag is set and both error flags are 0; otherwise cpu_run stays 0.
- **RUN → LOAD** if initialize rises again. cpu_run drops the same cycle and the status is re-cleared.
- **Fetch:**
  - fetch_instr is registered from `mem[fetch_addr[AW+1:2]]`: 1-cycle latency.
  - Upper address bits are ignored; the index wraps modulo DEPTH.
  - fetch_instr is forced to 0 while the state is LOAD or DUMP.
- **Dump:**
  - dump_start is honoured only in RUN or IDLE with the written flag set; otherwise it is ignored.
  - It enters DUMP with index 0 and cpu_run = 0.
  - dump_valid rises 1 cycle later, after the registered read.
  - A word transfers when dump_valid & dump_ready. The index then increments, and the next word is valid on the following cycle.
  - dump_data and dump_index hold stable while dump_valid=1 and dump_ready=0.
  - After transferring index max_index: dump_valid drops and the FSM returns to RUN, restoring cpu_run per the error flags.
  - initialize=1 during DUMP aborts to LOAD, with dump_valid = 0 the same cycle.
- **Simultaneous events:**
  - initialize has priority over dump_start.
  - dump_start while already in DUMP is ignored.

Test Plan:
1. **Basic load and fetch.** Reset, then load:
   - addr 0 = 0x00020820
   - addr 4 = 0x20620001
   - addr 8 = 0x20620002
   - addr 12 = 0x20620003
   - addr 16 = 0x20620004

   Hold each pair 2 cycles, then drop initialize.
   - Required: load_done pulses once, max_index=4, cpu_run=1.
   - Fetch addr 8 returns 0x20620002 one cycle later.
2. **Error flags.**
   - Load addr 6 → err_misaligned=1, cpu_run stays 0, mem[1] unchanged.
   - Load addr 256 (DEPTH=64) → err_range=1.
   - Reload with clean addresses → both flags clear, cpu_run=1.
3. **Dump with backpressure.** After scenario 1, pulse dump_start and toggle dump_ready 1,0,0,1,…
   - Required: five transfers with indices 0..4, data matching the loaded words, data stable during stalls, cpu_run=0 during the dump and 1 after.
4. **Aborts.**
   - Assert initialize mid-dump → dump_valid=0 the same cycle, state LOAD, fetch_instr=0.
   - Deassert rst mid-load → all outputs 0 immediately, asynchronously (no clock edge needed).
5. **Fetch wrap.** fetch_addr = 0x00000104 with DEPTH=64 → returns mem[1].
6. **Empty load.** initialize pulsed high for 1 cycle with an out-of-range address only → load_done pulses, cpu_run=0, dump_start ignored.

Source files
------------

// File: rtl/instr_mem_init_responder.sv
// -----------------------------------------------------------------------------
// instr_mem_init_responder
//
// Responder end of the instruction-initialize interface. While `initialize` is
// high, address/data pairs are written into a word-addressed instruction RAM.
// Once loading stops, the RAM serves the CPU fetch port with a 1-cycle
// registered read. A valid/ready readback stream lets a host dump words
// 0..max_index.
//
// Ports
//   clk, rst                        clock (rising edge), async active-low reset
//   initialize                      high = load mode (fetch and dump blocked)
//   instruction_initialize_address  byte address of the word to write
//   instruction_initialize_data     instruction word to write
//   fetch_addr / fetch_instr        CPU fetch, 1-cycle registered read
//   cpu_run                         program loaded and error-free
//   load_done                       1-cycle pulse on leaving load mode
//   max_index                       highest word index written this load
//   err_misaligned, err_range       sticky load-address error flags
//   dump_start                      request to stream words 0..max_index
//   dump_valid/ready/data/index     readback stream
// -----------------------------------------------------------------------------
module instr_mem_init_responder #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          initialize,
  input  logic [31:0]   instruction_initialize_address,
  input  logic [31:0]   instruction_initialize_data,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic          cpu_run,
  output logic          load_done,
  output logic [AW-1:0] max_index,
  output logic          err_misaligned,
  output logic          err_range,
  input  logic          dump_start,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [31:0]   dump_data,
  output logic [AW-1:0] dump_index
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]   r_mem [DEPTH];

  logic          r_written;
  logic          r_err_mis;
  logic          r_err_rng;
  logic [AW-1:0] r_max_index;
  logic [31:0]   r_fetch_instr;
  logic          r_dump_valid;
  logic [31:0]   r_dump_data;
  logic [AW-1:0] r_dump_index;

  logic          w_mis;
  logic          w_rng;
  logic          w_load_cycle;
  logic          w_wr_en;
  logic          w_enter_load;
  logic          w_dump_go;
  logic          w_dump_first;
  logic          w_dump_xfer;
  logic          w_dump_last;
  logic [AW-1:0] w_wr_index;
  logic [AW-1:0] w_fetch_index;
  logic [AW-1:0] w_dump_rd_index;

  // Load address decode: anything at or above DEPTH*4 bytes is out of range.
  assign w_mis        = |instruction_initialize_address[1:0];
  assign w_rng        = |instruction_initialize_address[31:AW+2];
  assign w_wr_index   = instruction_initialize_address[AW+1:2];
  assign w_load_cycle = (r_state == S_LOAD) && initialize;
  assign w_wr_en      = w_load_cycle && !w_mis && !w_rng;

  // The first cycle of initialize (from any other state) only clears status;
  // writes happen on the following LOAD cycles.
  assign w_enter_load = initialize && (r_state != S_LOAD);

  // initialize wins over dump_start; an empty or fresh load cannot be dumped.
  assign w_dump_go    = dump_start && !initialize && r_written &&
                        ((r_state == S_RUN) || (r_state == S_IDLE));

  // First DUMP cycle performs the read of word 0; afterwards each accepted
  // word immediately fetches the next one so the stream has no bubbles.
  assign w_dump_first = (r_state == S_DUMP) && !r_dump_valid;
  assign w_dump_xfer  = (r_state == S_DUMP) && r_dump_valid && dump_ready && !initialize;
  assign w_dump_last  = w_dump_xfer && (r_dump_index == r_max_index);
  assign w_dump_rd_index = w_dump_first ? '0 : r_dump_index + AW'(1);

  assign w_fetch_index = fetch_addr[AW+1:2];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of block ordering.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (initialize)     w_next_state = S_LOAD;
        else if (w_dump_go) w_next_state = S_DUMP;
      end
      S_LOAD: begin
        if (!initialize)    w_next_state = S_RUN;
      end
      S_RUN: begin
        if (initialize)     w_next_state = S_LOAD;
        else if (w_dump_go) w_next_state = S_DUMP;
      end
      S_DUMP: begin
        if (initialize)       w_next_state = S_LOAD;
        else if (w_dump_last) w_next_state = S_RUN;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_written   <= 1'b0;
      r_err_mis   <= 1'b0;
      r_err_rng   <= 1'b0;
      r_max_index <= '0;
    end else if (w_enter_load) begin
      r_written   <= 1'b0;
      r_err_mis   <= 1'b0;
      r_err_rng   <= 1'b0;
      r_max_index <= '0;
    end else if (w_load_cycle) begin
      if (w_mis) r_err_mis <= 1'b1;
      if (w_rng) r_err_rng <= 1'b1;
      if (w_wr_en) begin
        r_written <= 1'b1;
        if (w_wr_index > r_max_index) r_max_index <= w_wr_index;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction RAM
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset so it maps onto RAM primitives; a loaded
  // program survives rst.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_index] <= instruction_initialize_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fetch_instr <= '0;
    else      r_fetch_instr <= r_mem[w_fetch_index];
  end

  // ---------------------------------------------------------------------------
  // Dump stream
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dump_valid <= 1'b0;
      r_dump_data  <= '0;
      r_dump_index <= '0;
    end else if (initialize || (r_state != S_DUMP)) begin
      r_dump_valid <= 1'b0;
      if (w_dump_go) r_dump_index <= '0;
    end else if (w_dump_first || (w_dump_xfer && !w_dump_last)) begin
      r_dump_valid <= 1'b1;
      r_dump_data  <= r_mem[w_dump_rd_index];
      r_dump_index <= w_dump_rd_index;
    end else if (w_dump_last) begin
      r_dump_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (initialize gates run/valid in the same cycle it rises)
  // ---------------------------------------------------------------------------
  assign fetch_instr    = ((r_state == S_LOAD) || (r_state == S_DUMP)) ? '0 : r_fetch_instr;
  assign cpu_run        = (r_state == S_RUN) && !initialize && r_written &&
                          !r_err_mis && !r_err_rng;
  assign load_done      = (r_state == S_LOAD) && !initialize;
  assign max_index      = r_max_index;
  assign err_misaligned = r_err_mis;
  assign err_range      = r_err_rng;
  assign dump_valid     = r_dump_valid && (r_state == S_DUMP) && !initialize;
  assign dump_data      = r_dump_data;
  assign dump_index     = r_dump_index;

endmodule

// File: tb/tb_instr_mem_init_responder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for instr_mem_init_responder. A program-level model
// (word array plus load status derived from the list of address/data cycles)
// predicts fetch results, load status and dump contents.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_mem_init_responder;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk;
  logic          rst;
  logic          initialize;
  logic [31:0]   instruction_initialize_address;
  logic [31:0]   instruction_initialize_data;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_instr;
  logic          cpu_run;
  logic          load_done;
  logic [AW-1:0] max_index;
  logic          err_misaligned;
  logic          err_range;
  logic          dump_start;
  logic          dump_valid;
  logic          dump_ready;
  logic [31:0]   dump_data;
  logic [AW-1:0] dump_index;

  instr_mem_init_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .initialize                     (initialize),
    .instruction_initialize_address (instruction_initialize_address),
    .instruction_initialize_data    (instruction_initialize_data),
    .fetch_addr                     (fetch_addr),
    .fetch_instr                    (fetch_instr),
    .cpu_run                        (cpu_run),
    .load_done                      (load_done),
    .max_index                      (max_index),
    .err_misaligned                 (err_misaligned),
    .err_range                      (err_range),
    .dump_start                     (dump_start),
    .dump_valid                     (dump_valid),
    .dump_ready                     (dump_ready),
    .dump_data                      (dump_data),
    .dump_index                     (dump_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem [DEPTH];
  bit          m_val [DEPTH];
  int          m_max;
  bit          m_written, m_mis, m_rng;

  logic [31:0] cyc_addr[$];
  logic [31:0] cyc_data[$];

  function automatic bit m_ok();
    return m_written && !m_mis && !m_rng;
  endfunction

  task automatic model_clear();
    m_max = 0; m_written = 0; m_mis = 0; m_rng = 0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    bit mis, rng;
    int idx;
    mis = (a % 4) != 0;
    rng = a >= DEPTH * 4;
    if (mis) m_mis = 1;
    if (rng) m_rng = 1;
    if (!mis && !rng) begin
      idx = int'(a / 4);
      m_mem[idx] = d;
      m_val[idx] = 1;
      m_written  = 1;
      if (idx > m_max) m_max = idx;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_pair(input logic [31:0] a, input logic [31:0] d, input int hold);
    repeat (hold) begin
      cyc_addr.push_back(a);
      cyc_data.push_back(d);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fetch"}, fetch_instr, 0);
    check({tag, "_run"},   32'(cpu_run), 0);
    check({tag, "_done"},  32'(load_done), 0);
    check({tag, "_max"},   32'(max_index), 0);
    check({tag, "_mis"},   32'(err_misaligned), 0);
    check({tag, "_rng"},   32'(err_range), 0);
    check({tag, "_dv"},    32'(dump_valid), 0);
    check({tag, "_dd"},    dump_data, 0);
    check({tag, "_di"},    32'(dump_index), 0);
  endtask

  // Plays the queued cycles with initialize high, then drops it. Cycle 0 is
  // the entry cycle (status cleared, nothing written).
  task automatic run_load();
    int pulses;
    pulses = 0;
    for (int c = 0; c < cyc_addr.size(); c++) begin
      initialize = 1'b1;
      instruction_initialize_address = cyc_addr[c];
      instruction_initialize_data    = cyc_data[c];
      #1;
      pulses += int'(load_done);
      if (c == 0) begin
        check("run_drops_on_init", 32'(cpu_run), 0);
        check("dv_drops_on_init",  32'(dump_valid), 0);
      end else begin
        check("fetch_blocked_load", fetch_instr, 0);
      end
      tick();
      if (c == 0) model_clear();
      else        model_write(cyc_addr[c], cyc_data[c]);
    end
    initialize = 1'b0;
    #1;
    check("load_done_high", 32'(load_done), 1);
    pulses += int'(load_done);
    tick();
    pulses += int'(load_done);
    check("load_done_count", 32'(pulses), 1);
    check("cpu_run_after",   32'(cpu_run), 32'(m_ok()));
    check("max_index",       32'(max_index), 32'(m_max));
    check("err_misaligned",  32'(err_misaligned), 32'(m_mis));
    check("err_range",       32'(err_range), 32'(m_rng));
    cyc_addr.delete();
    cyc_data.delete();
  endtask

  task automatic fetch_check(input logic [31:0] a);
    int idx;
    idx = int'((a >> 2) % DEPTH);
    fetch_addr = a;
    tick();
    if (m_val[idx]) check("fetch", fetch_instr, m_mem[idx]);
  endtask

  // mode 0: ready pattern 1,0,0,1 repeating; mode 1: random ready.
  task automatic run_dump(input int mode);
    int   exp_idx, budget, k;
    logic r;
    bit   pat [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    dump_ready = 1'b0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("dump_run_low",   32'(cpu_run), 0);
    check("dump_valid_lat", 32'(dump_valid), 0);
    tick();
    exp_idx = 0;
    budget  = 400;
    k       = 0;
    while (exp_idx <= m_max && budget > 0) begin
      r = (mode == 0) ? pat[k % 4] : 1'($urandom_range(0, 1));
      dump_ready = r;
      #1;
      check("dump_valid", 32'(dump_valid), 1);
      check("dump_index", 32'(dump_index), 32'(exp_idx));
      check("dump_run_low2", 32'(cpu_run), 0);
      if (m_val[exp_idx]) check("dump_data", dump_data, m_mem[exp_idx]);
      if (r) exp_idx++;
      k++;
      budget--;
      tick();
    end
    dump_ready = 1'b0;
    check("dump_budget",    32'(budget > 0), 1);
    check("dump_transfers", 32'(exp_idx), 32'(m_max + 1));
    check("dump_end_valid", 32'(dump_valid), 0);
    check("dump_end_run",   32'(cpu_run), 32'(m_ok()));
  endtask

  task automatic dump_ignored();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("dump_ign_valid0", 32'(dump_valid), 0);
    tick();
    check("dump_ign_valid1", 32'(dump_valid), 0);
    check("dump_ign_run",    32'(cpu_run), 32'(m_ok()));
  endtask

  task automatic random_rounds(input int rounds);
    int          n, sel;
    logic [31:0] a;
    for (int it = 0; it < rounds; it++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        sel = $urandom_range(0, 9);
        a   = 32'($urandom_range(0, DEPTH - 1)) * 4;
        if (sel == 0)      a = a + 32'($urandom_range(1, 3));
        else if (sel == 1) a = a + 32'(DEPTH * 4) * 32'($urandom_range(1, 1000));
        add_pair(a, $urandom, (k == 0) ? $urandom_range(2, 3) : $urandom_range(1, 3));
      end
      run_load();
      repeat (6) fetch_check($urandom);
      if (m_written) run_dump(1);
      else           dump_ignored();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
    model_clear();
    rst = 1'b1;
    initialize = 1'b0;
    instruction_initialize_address = '0;
    instruction_initialize_data = '0;
    fetch_addr = '0;
    dump_start = 1'b0;
    dump_ready = 1'b0;

    // Reset
    #3 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick();
    check("idle_run", 32'(cpu_run), 0);

    // 1. Basic load and fetch
    add_pair(32'd0,  32'h00020820, 2);
    add_pair(32'd4,  32'h20620001, 2);
    add_pair(32'd8,  32'h20620002, 2);
    add_pair(32'd12, 32'h20620003, 2);
    add_pair(32'd16, 32'h20620004, 2);
    run_load();
    check("t1_max", 32'(max_index), 4);
    check("t1_run", 32'(cpu_run), 1);
    fetch_addr = 32'd8;
    tick();
    check("t1_fetch8", fetch_instr, 32'h20620002);

    // 3. Dump with backpressure 1,0,0,1,...
    run_dump(0);

    // 5. Fetch wrap: 0x104 aliases word 1
    fetch_addr = 32'h0000_0104;
    tick();
    check("t5_wrap", fetch_instr, 32'h20620001);

    // 2. Error flags
    add_pair(32'd0, 32'h00020820, 2);
    add_pair(32'd6, 32'hBAD0_0006, 2);
    run_load();
    check("t2_mis", 32'(err_misaligned), 1);
    check("t2_run", 32'(cpu_run), 0);
    fetch_check(32'd4);
    check("t2_mem1", fetch_instr, 32'h20620001);
    add_pair(32'd256, 32'hBAD0_0100, 2);
    run_load();
    check("t2_rng", 32'(err_range), 1);
    add_pair(32'd4, 32'h20620001, 2);
    add_pair(32'd8, 32'h20620002, 1);
    run_load();
    check("t2_clean_run", 32'(cpu_run), 1);

    // 4a. Abort mid-dump
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    dump_ready = 1'b1;
    tick();
    dump_ready = 1'b0;
    initialize = 1'b1;
    #1;
    check("t4_abort_dv",    32'(dump_valid), 0);
    check("t4_abort_fetch", fetch_instr, 0);
    add_pair(32'd0,  32'h00020820, 2);
    add_pair(32'd4,  32'h20620001, 1);
    add_pair(32'd8,  32'h20620002, 1);
    add_pair(32'd12, 32'h20620003, 1);
    add_pair(32'd16, 32'h20620004, 1);
    run_load();
    check("t4_reload_run", 32'(cpu_run), 1);

    // 4b. Async reset mid-load
    initialize = 1'b1;
    instruction_initialize_address = 32'd20;
    instruction_initialize_data    = 32'hCAFE_0005;
    tick();
    model_clear();
    tick();
    model_write(32'd20, 32'hCAFE_0005);
    check("t4_pre_reset_max", 32'(max_index), 5);
    #2 rst = 1'b0;
    #1 check_all_zero("t4_async_rst");
    initialize = 1'b0;
    model_clear();
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    fetch_check(32'd20);
    check("t4_ram_kept", fetch_instr, 32'hCAFE_0005);
    dump_ignored();

    // 6. Empty load: 1-cycle initialize with an out-of-range address
    add_pair(32'd4, 32'h20620001, 2);
    run_load();
    add_pair(32'h0000_1000, 32'h1234_5678, 1);
    run_load();
    check("t6_run", 32'(cpu_run), 0);
    dump_ignored();

    // Randomized programs
    random_rounds(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
